// File: rtl/spram_boot_sequencer_if.sv
// Bus bundle between the boot sequencer, the SPI read FIFO, the SPRAM banks and the SoC.
interface spram_boot_sequencer_if #(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned ADDR_W    = 14
);
    logic                 ip_done_i;
    logic                 spi_we_i;
    logic [31:0]          spi_data_i;
    logic                 fill_o;
    logic                 fifo_rst_o;
    logic [23:0]          flash_addr_o;
    logic [NUM_BANKS-1:0] mem_sel_o;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic [31:0]          mem_data_o;
    logic                 mem_we_o;
    logic                 soc_rstn_o;
    logic                 busy_o;
    logic                 load_err_o;

    // Sequencer side.
    modport master (
        input  ip_done_i, spi_we_i, spi_data_i,
        output fill_o, fifo_rst_o, flash_addr_o, mem_sel_o, mem_addr_o, mem_data_o,
               mem_we_o, soc_rstn_o, busy_o, load_err_o
    );

    // FIFO / SPRAM / SoC side.
    modport slave (
        output ip_done_i, spi_we_i, spi_data_i,
        input  fill_o, fifo_rst_o, flash_addr_o, mem_sel_o, mem_addr_o, mem_data_o,
               mem_we_o, soc_rstn_o, busy_o, load_err_o
    );
endinterface

// File: rtl/spram_boot_sequencer.sv
// Boot-time loader: copies one flash image per SPRAM bank through the SPI read FIFO, resets
// the FIFO between banks, then hands the banks to the SoC once the hard IP reports done.
module spram_boot_sequencer #(
    parameter int unsigned             NUM_BANKS  = 2,
    parameter int unsigned             ADDR_W     = 14,
    parameter logic [24*NUM_BANKS-1:0] FLASH_BASE = {24'h050000, 24'h030000},
    parameter logic [31:0]             END_MARKER = 32'hFFFF_FFFF,
    parameter int unsigned             GAP_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    spram_boot_sequencer_if.master bus
);

    localparam int unsigned BankW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {StStart, StFill, StGap, StWaitIp, StDone} state_e;

    state_e               state_q, state_d;
    logic [BankW-1:0]     bank_q, bank_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [GapW-1:0]      gap_q, gap_d;
    logic [23:0]          flash_addr_q, flash_addr_d;
    logic                 load_err_q, load_err_d;
    logic                 fill_q, fill_d;
    logic                 fifo_rst_q, fifo_rst_d;
    logic [NUM_BANKS-1:0] mem_sel_q, mem_sel_d;
    logic                 soc_rstn_q, soc_rstn_d;
    logic                 busy_q, busy_d;
    logic                 mem_we;
    logic                 is_marker;
    logic                 last_bank;
    logic [BankW-1:0]     next_bank;
    logic [23:0]          bank_base [NUM_BANKS];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_base
        assign bank_base[g] = FLASH_BASE[24*g +: 24];
    end

    assign is_marker = (bus.spi_data_i == END_MARKER);
    assign last_bank = (bank_q == BankW'(NUM_BANKS - 1));
    assign next_bank = bank_q + BankW'(1);

    // Next-state logic: bank sequencing, word counting and end/overflow detection.
    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        flash_addr_d = flash_addr_q;
        load_err_d   = load_err_q;
        mem_we       = 1'b0;
        case (state_q)
            StStart: state_d = StFill;
            StFill: begin
                if (bus.spi_we_i) begin
                    // Marker wins over overflow: a marker at the last address is not an error.
                    if (is_marker) begin
                        state_d = StGap;
                        cnt_d   = '0;
                    end else begin
                        mem_we = 1'b1;
                        if (cnt_q == '1) begin
                            load_err_d = 1'b1;
                            state_d    = StGap;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + ADDR_W'(1);
                        end
                    end
                    // Publish the next base on GAP entry so it is settled before the next fill.
                    if (state_d == StGap) begin
                        gap_d = '0;
                        if (!last_bank) begin
                            flash_addr_d = bank_base[next_bank];
                        end
                    end
                end
            end
            StGap: begin
                if (gap_q == GapW'(GAP_CYCLES - 1)) begin
                    if (!last_bank) begin
                        bank_d  = next_bank;
                        state_d = StFill;
                    end else begin
                        state_d = StWaitIp;
                    end
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            StWaitIp: begin
                if (bus.ip_done_i) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StDone;
            default: state_d = StStart;
        endcase
    end

    // Registered outputs decoded from the upcoming state so they change with the state.
    always_comb begin
        fill_d     = (state_d == StFill);
        fifo_rst_d = (state_d != StFill);
        soc_rstn_d = (state_d == StDone);
        busy_d     = (state_d != StDone);
        mem_sel_d  = '0;
        if (state_d == StFill) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                mem_sel_d[i] = (bank_d == BankW'(i));
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StStart;
            bank_q       <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            flash_addr_q <= FLASH_BASE[23:0];
            load_err_q   <= 1'b0;
            fill_q       <= 1'b0;
            fifo_rst_q   <= 1'b1;
            mem_sel_q    <= '0;
            soc_rstn_q   <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            flash_addr_q <= flash_addr_d;
            load_err_q   <= load_err_d;
            fill_q       <= fill_d;
            fifo_rst_q   <= fifo_rst_d;
            mem_sel_q    <= mem_sel_d;
            soc_rstn_q   <= soc_rstn_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.fill_o       = fill_q;
    assign bus.fifo_rst_o   = fifo_rst_q;
    assign bus.flash_addr_o = flash_addr_q;
    assign bus.mem_sel_o    = mem_sel_q;
    assign bus.mem_addr_o   = cnt_q;
    assign bus.mem_data_o   = bus.spi_data_i;
    assign bus.mem_we_o     = mem_we;
    assign bus.soc_rstn_o   = soc_rstn_q;
    assign bus.busy_o       = busy_q;
    assign bus.load_err_o   = load_err_q;

endmodule

// File: tb/tb_spram_boot_sequencer.sv
// Directed bench for the SPRAM boot sequencer (two banks, 4-bit word address, 2-cycle gap).
module tb_spram_boot_sequencer;

    localparam logic [31:0] Marker = 32'hFFFF_FFFF;

    logic clk_i;
    logic rst_i;
    int   n_vec;
    int   n_err;

    spram_boot_sequencer_if #(.NUM_BANKS(2), .ADDR_W(4)) bus ();

    spram_boot_sequencer #(
        .NUM_BANKS  (2),
        .ADDR_W     (4),
        .FLASH_BASE ({24'h050000, 24'h030000}),
        .END_MARKER (32'hFFFF_FFFF),
        .GAP_CYCLES (2)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, then let combinational outputs settle.
    task automatic cyc(input logic we, input logic [31:0] d);
        @(posedge clk_i);
        #1;
        bus.spi_we_i   = we;
        bus.spi_data_i = d;
        #1;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_fill"},     32'(bus.fill_o),       32'd0);
        check({tag, "_fifo_rst"}, 32'(bus.fifo_rst_o),   32'd1);
        check({tag, "_flash"},    32'(bus.flash_addr_o), 32'h030000);
        check({tag, "_sel"},      32'(bus.mem_sel_o),    32'd0);
        check({tag, "_addr"},     32'(bus.mem_addr_o),   32'd0);
        check({tag, "_we"},       32'(bus.mem_we_o),     32'd0);
        check({tag, "_soc_rstn"}, 32'(bus.soc_rstn_o),   32'd0);
        check({tag, "_busy"},     32'(bus.busy_o),       32'd1);
        check({tag, "_load_err"}, 32'(bus.load_err_o),   32'd0);
    endtask

    // Two GAP cycles; a valid non-marker word in the first must not be written.
    task automatic gap_phase(input string tag, input logic [23:0] flash);
        for (int i = 0; i < 2; i++) begin
            cyc((i == 0), 32'h5555_5555);
            check({tag, "_fill"},     32'(bus.fill_o),       32'd0);
            check({tag, "_fifo_rst"}, 32'(bus.fifo_rst_o),   32'd1);
            check({tag, "_sel"},      32'(bus.mem_sel_o),    32'd0);
            check({tag, "_we"},       32'(bus.mem_we_o),     32'd0);
            check({tag, "_flash"},    32'(bus.flash_addr_o), 32'(flash));
        end
    endtask

    // Pulse reset and leave the sequencer in its START cycle.
    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i        = 1'b1;
        bus.spi_we_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_i          = 1'b1;
        bus.ip_done_i  = 1'b0;
        bus.spi_we_i   = 1'b0;
        bus.spi_data_i = '0;
        repeat (2) @(posedge clk_i);

        // Reset values, with a valid word present to prove the write is gated.
        cyc(1'b1, 32'h1234_5678);
        chk_reset("rst");

        // START cycle.
        @(posedge clk_i);
        #1;
        rst_i        = 1'b0;
        bus.spi_we_i = 1'b0;
        #1;
        check("start_fill", 32'(bus.fill_o), 32'd0);
        check("start_fifo_rst", 32'(bus.fifo_rst_o), 32'd1);

        // Bank0: five words, the first two followed by three idle cycles, then the marker.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'hA000_0000 + 32'(i));
            check("b0_we", 32'(bus.mem_we_o), 32'd1);
            check("b0_addr", 32'(bus.mem_addr_o), 32'(i));
            check("b0_sel", 32'(bus.mem_sel_o), 32'b01);
            check("b0_fill", 32'(bus.fill_o), 32'd1);
            check("b0_fifo_rst", 32'(bus.fifo_rst_o), 32'd0);
            check("b0_data", bus.mem_data_o, 32'hA000_0000 + 32'(i));
            check("b0_flash", 32'(bus.flash_addr_o), 32'h030000);
            if (i < 2) begin
                for (int k = 0; k < 3; k++) begin
                    cyc(1'b0, 32'hDEAD_BEEF);
                    check("idle_we", 32'(bus.mem_we_o), 32'd0);
                    check("idle_addr", 32'(bus.mem_addr_o), 32'(i + 1));
                end
            end
        end
        cyc(1'b1, Marker);
        check("b0_marker_we", 32'(bus.mem_we_o), 32'd0);
        check("b0_marker_fill", 32'(bus.fill_o), 32'd1);
        gap_phase("gap0", 24'h050000);

        // Bank1: three words and the marker.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'hB000_0000 + 32'(i));
            check("b1_we", 32'(bus.mem_we_o), 32'd1);
            check("b1_addr", 32'(bus.mem_addr_o), 32'(i));
            check("b1_sel", 32'(bus.mem_sel_o), 32'b10);
            check("b1_flash", 32'(bus.flash_addr_o), 32'h050000);
        end
        cyc(1'b1, Marker);
        check("b1_marker_we", 32'(bus.mem_we_o), 32'd0);
        gap_phase("gap1", 24'h050000);

        // WAIT_IP for ten cycles, then ip_done.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 32'h0);
            check("wait_fill", 32'(bus.fill_o), 32'd0);
            check("wait_fifo_rst", 32'(bus.fifo_rst_o), 32'd1);
            check("wait_soc_rstn", 32'(bus.soc_rstn_o), 32'd0);
            check("wait_busy", 32'(bus.busy_o), 32'd1);
        end
        @(posedge clk_i);
        #1;
        bus.ip_done_i = 1'b1;
        #1;
        check("ipdone_same_cycle", 32'(bus.soc_rstn_o), 32'd0);
        cyc(1'b0, 32'h0);
        check("done_soc_rstn", 32'(bus.soc_rstn_o), 32'd1);
        check("done_busy", 32'(bus.busy_o), 32'd0);
        check("done_sel", 32'(bus.mem_sel_o), 32'd0);
        check("done_fifo_rst", 32'(bus.fifo_rst_o), 32'd1);
        bus.ip_done_i = 1'b0;
        cyc(1'b1, 32'h1111_1111);
        check("done_hold_soc_rstn", 32'(bus.soc_rstn_o), 32'd1);
        check("done_hold_we", 32'(bus.mem_we_o), 32'd0);
        check("done_hold_busy", 32'(bus.busy_o), 32'd0);

        // Overflow: sixteen words, no marker.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 32'hC000_0000 + 32'(i));
            check("ovf_addr", 32'(bus.mem_addr_o), 32'(i));
            check("ovf_we", 32'(bus.mem_we_o), 32'd1);
            check("ovf_err_pre", 32'(bus.load_err_o), 32'd0);
        end
        cyc(1'b0, 32'h0);
        check("ovf_err", 32'(bus.load_err_o), 32'd1);
        check("ovf_gap_fill", 32'(bus.fill_o), 32'd0);
        check("ovf_gap_fifo_rst", 32'(bus.fifo_rst_o), 32'd1);
        cyc(1'b0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 32'hD000_0000 + 32'(i));
            check("ovf_b1_addr", 32'(bus.mem_addr_o), 32'(i));
            check("ovf_b1_sel", 32'(bus.mem_sel_o), 32'b10);
            check("ovf_err_sticky", 32'(bus.load_err_o), 32'd1);
        end

        // Asynchronous reset during bank1 at address 7.
        cyc(1'b1, 32'hD000_0007);
        check("midrst_addr", 32'(bus.mem_addr_o), 32'd7);
        #2;
        rst_i = 1'b1;
        #1;
        chk_reset("midrst");
        @(posedge clk_i);
        #1;
        rst_i        = 1'b0;
        bus.spi_we_i = 1'b0;
        #1;
        cyc(1'b1, 32'hE000_0000);
        check("restart_fill", 32'(bus.fill_o), 32'd1);
        check("restart_flash", 32'(bus.flash_addr_o), 32'h030000);
        check("restart_addr", 32'(bus.mem_addr_o), 32'd0);
        check("restart_sel", 32'(bus.mem_sel_o), 32'b01);
        check("restart_we", 32'(bus.mem_we_o), 32'd1);

        // ip_done held from reset; bank0 marker lands at the last address (no error).
        bus.ip_done_i = 1'b1;
        do_reset();
        check("early_ip_soc_rstn", 32'(bus.soc_rstn_o), 32'd0);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 32'hF000_0000 + 32'(i));
        end
        cyc(1'b1, Marker);
        check("last_marker_addr", 32'(bus.mem_addr_o), 32'd15);
        check("last_marker_we", 32'(bus.mem_we_o), 32'd0);
        gap_phase("gap_early", 24'h050000);
        check("marker_prio_err", 32'(bus.load_err_o), 32'd0);
        cyc(1'b1, Marker);
        check("early_b1_sel", 32'(bus.mem_sel_o), 32'b10);
        check("early_b1_soc_rstn", 32'(bus.soc_rstn_o), 32'd0);
        gap_phase("gap_early1", 24'h050000);
        check("early_gap_soc_rstn", 32'(bus.soc_rstn_o), 32'd0);
        cyc(1'b0, 32'h0);
        check("early_wait_soc_rstn", 32'(bus.soc_rstn_o), 32'd0);
        check("early_wait_busy", 32'(bus.busy_o), 32'd1);
        cyc(1'b0, 32'h0);
        check("early_done_soc_rstn", 32'(bus.soc_rstn_o), 32'd1);
        check("early_done_busy", 32'(bus.busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
